// File: rtl/board_state.sv
// Locked-cell playfield: answers candidate-move legality, locks pieces and clears full rows.
// Latency: checks/reads combinational; lock visible 1 cycle after capture; busy 21..105 cycles per lock.
// Backpressure: BOARD_BUSY high while locking/clearing; can_move forced to 0 and lock requests ignored meanwhile.
module board_state #(
  parameter int COLS = 10,
  parameter int ROWS = 20,
  parameter int CW   = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [19:0]   x_block,
  input  logic [19:0]   y_block,
  input  logic [CW-1:0] block,
  input  logic          get_new_block,
  input  logic [19:0]   x_move_left,
  input  logic [19:0]   y_move_left,
  input  logic [19:0]   x_move_right,
  input  logic [19:0]   y_move_right,
  input  logic [19:0]   x_rotate_right,
  input  logic [19:0]   y_rotate_right,
  input  logic [19:0]   x_rotate_left,
  input  logic [19:0]   y_rotate_left,
  input  logic [19:0]   x_move_down,
  input  logic [19:0]   y_move_down,
  input  logic [4:0]    x_coord,
  input  logic [4:0]    y_coord,
  output logic [4:0]    can_move,
  output logic          BOARD_BUSY,
  output logic          cell_occupied,
  output logic [CW-1:0] cell_color,
  output logic [15:0]   lines_cleared,
  output logic          game_over
);

  localparam int         XW       = $clog2(COLS);
  localparam logic [4:0] COLS_C   = 5'(COLS);
  localparam logic [4:0] ROWS_C   = 5'(ROWS);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOCK, S_SCAN, S_SHIFT} state_t;

  state_t              state_q, state_d;
  logic [COLS-1:0]     occ_q [ROWS];
  logic [COLS-1:0]     occ_d [ROWS];
  logic [CW-1:0]       col_q [ROWS][COLS];
  logic [CW-1:0]       col_d [ROWS][COLS];
  logic [19:0]         hx_q, hx_d, hy_q, hy_d;
  logic [CW-1:0]       hc_q, hc_d;
  logic [4:0]          r_q, r_d, s_q, s_d;
  logic [15:0]         lines_q, lines_d;
  logic                go_q, go_d;
  logic                busy_q, busy_d;
  logic [4:0]          lock_x, lock_y;

  // A single cell is usable if it is on the board and not already locked.
  function automatic logic cell_free(input logic [4:0] cx, input logic [4:0] cy);
    logic ok;
    ok = 1'b0;
    if ((cx < COLS_C) && (cy < ROWS_C)) ok = ~occ_q[cy][cx[XW-1:0]];
    return ok;
  endfunction

  function automatic logic piece_free(input logic [19:0] px, input logic [19:0] py);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) ok = ok & cell_free(px[5*i +: 5], py[5*i +: 5]);
    return ok;
  endfunction

  // Candidate legality; nothing may move while the board is being rewritten.
  always_comb begin
    can_move = 5'b0;
    if (!busy_q) begin
      can_move = {piece_free(x_move_left,    y_move_left),
                  piece_free(x_move_right,   y_move_right),
                  piece_free(x_rotate_right, y_rotate_right),
                  piece_free(x_rotate_left,  y_rotate_left),
                  piece_free(x_move_down,    y_move_down)};
    end
  end

  // Display read port; off-board addresses read as empty.
  always_comb begin
    cell_occupied = 1'b0;
    cell_color    = '0;
    if ((x_coord < COLS_C) && (y_coord < ROWS_C)) begin
      cell_occupied = occ_q[y_coord][x_coord[XW-1:0]];
      cell_color    = col_q[y_coord][x_coord[XW-1:0]];
    end
  end

  // Next-state: capture, lock, bottom-up row scan, and one-row-per-cycle shift-down.
  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    col_d   = col_q;
    hx_d    = hx_q;
    hy_d    = hy_q;
    hc_d    = hc_q;
    r_d     = r_q;
    s_d     = s_q;
    lines_d = lines_q;
    go_d    = go_q;
    lock_x  = 5'd0;
    lock_y  = 5'd0;
    case (state_q)
      S_IDLE: begin
        if (get_new_block) begin
          hx_d    = x_block;
          hy_d    = y_block;
          hc_d    = block;
          state_d = S_LOCK;
        end
      end
      S_LOCK: begin
        for (int i = 0; i < 4; i++) begin
          lock_x = hx_q[5*i +: 5];
          lock_y = hy_q[5*i +: 5];
          if ((lock_x < COLS_C) && (lock_y < ROWS_C)) begin
            occ_d[lock_y][lock_x[XW-1:0]] = 1'b1;
            col_d[lock_y][lock_x[XW-1:0]] = hc_q;
          end
          if (lock_y == 5'd0) go_d = 1'b1;
        end
        r_d     = LAST_ROW;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (&occ_q[r_q]) begin
          s_d     = r_q;
          state_d = S_SHIFT;
        end else if (r_q == 5'd0) begin
          state_d = S_IDLE;
        end else begin
          r_d = r_q - 5'd1;
        end
      end
      S_SHIFT: begin
        if (s_q != 5'd0) begin
          occ_d[s_q] = occ_q[s_q - 5'd1];
          col_d[s_q] = col_q[s_q - 5'd1];
          s_d        = s_q - 5'd1;
        end else begin
          // Top row gets fresh empty cells; rescan r since a new row dropped into it.
          occ_d[0] = '0;
          for (int c = 0; c < COLS; c++) col_d[0][c] = '0;
          lines_d = lines_q + 16'd1;
          state_d = S_SCAN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State registers with synchronous reset that wipes the board regardless of phase.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      occ_q   <= '{default: '0};
      col_q   <= '{default: '0};
      hx_q    <= '0;
      hy_q    <= '0;
      hc_q    <= '0;
      r_q     <= '0;
      s_q     <= '0;
      lines_q <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      col_q   <= col_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      hc_q    <= hc_d;
      r_q     <= r_d;
      s_q     <= s_d;
      lines_q <= lines_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
    end
  end

  assign BOARD_BUSY    = busy_q;
  assign lines_cleared = lines_q;
  assign game_over     = go_q;

endmodule

// File: tb/tb_board_state.sv
// Bench for board_state: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a whole-board model (lock, then compact full rows away).
// Drives inputs 1 time unit after the rising edge, compares on the falling edge.
module tb_board_state;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [19:0] x_block = '0, y_block = '0;
  logic [2:0]  block = '0;
  logic        get_new_block = 1'b0;
  logic [19:0] x_move_left = '0, y_move_left = '0, x_move_right = '0, y_move_right = '0;
  logic [19:0] x_rotate_right = '0, y_rotate_right = '0, x_rotate_left = '0, y_rotate_left = '0;
  logic [19:0] x_move_down = '0, y_move_down = '0;
  logic [4:0]  x_coord = '0, y_coord = '0;
  logic [4:0]  can_move;
  logic        BOARD_BUSY, cell_occupied, game_over;
  logic [2:0]  cell_color;
  logic [15:0] lines_cleared;

  board_state dut (
    .Clk(Clk), .Reset(Reset), .x_block(x_block), .y_block(y_block), .block(block),
    .get_new_block(get_new_block),
    .x_move_left(x_move_left), .y_move_left(y_move_left),
    .x_move_right(x_move_right), .y_move_right(y_move_right),
    .x_rotate_right(x_rotate_right), .y_rotate_right(y_rotate_right),
    .x_rotate_left(x_rotate_left), .y_rotate_left(y_rotate_left),
    .x_move_down(x_move_down), .y_move_down(y_move_down),
    .x_coord(x_coord), .y_coord(y_coord), .can_move(can_move), .BOARD_BUSY(BOARD_BUSY),
    .cell_occupied(cell_occupied), .cell_color(cell_color),
    .lines_cleared(lines_cleared), .game_over(game_over)
  );

  initial forever #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_occ [20][10];
  logic [2:0]  m_col [20][10];
  logic [15:0] m_lines;
  bit          m_go;
  int          busy_cnt;

  task automatic model_reset();
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) begin
        m_occ[y][x] = 1'b0;
        m_col[y][x] = 3'd0;
      end
    m_lines  = 16'd0;
    m_go     = 1'b0;
    busy_cnt = 0;
  endtask

  // Lock the piece, then drop every full row; each clear found at final row r costs r+2 cycles.
  task automatic model_lock();
    bit         n_occ [20][10];
    logic [2:0] n_col [20][10];
    int x, y, k, dur;
    bit full;
    for (int i = 0; i < 4; i++) begin
      x = int'(x_block[5*i +: 5]);
      y = int'(y_block[5*i +: 5]);
      if (x < 10 && y < 20) begin
        m_occ[y][x] = 1'b1;
        m_col[y][x] = block;
      end
      if (y == 0) m_go = 1'b1;
    end
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) begin
        n_occ[r][c] = 1'b0;
        n_col[r][c] = 3'd0;
      end
    k = 0;
    dur = 21;
    for (int r = 19; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < 10; c++) if (!m_occ[r][c]) full = 1'b0;
      if (full) begin
        dur += r + k + 2;
        k++;
      end else begin
        for (int c = 0; c < 10; c++) begin
          n_occ[r+k][c] = m_occ[r][c];
          n_col[r+k][c] = m_col[r][c];
        end
      end
    end
    m_occ = n_occ;
    m_col = n_col;
    m_lines = m_lines + 16'(k);
    busy_cnt = dur;
  endtask

  function automatic bit piece_ok(input logic [19:0] px, input logic [19:0] py);
    int x, y;
    for (int i = 0; i < 4; i++) begin
      x = int'(px[5*i +: 5]);
      y = int'(py[5*i +: 5]);
      if (x > 9 || y > 19) return 1'b0;
      if (m_occ[y][x]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [4:0] model_can();
    if (busy_cnt != 0) return 5'b0;
    return {piece_ok(x_move_left, y_move_left), piece_ok(x_move_right, y_move_right),
            piece_ok(x_rotate_right, y_rotate_right), piece_ok(x_rotate_left, y_rotate_left),
            piece_ok(x_move_down, y_move_down)};
  endfunction

  always @(posedge Clk) begin
    if (Reset) model_reset();
    else if (busy_cnt > 0) busy_cnt--;
    else if (get_new_block) model_lock();
  end

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("busy", 32'(BOARD_BUSY), 32'(busy_cnt != 0));
      check("can_move", 32'(can_move), 32'(model_can()));
      if (busy_cnt == 0) begin
        check("lines_cleared", 32'(lines_cleared), 32'(m_lines));
        check("game_over", 32'(game_over), 32'(m_go));
        if (x_coord < 5'd10 && y_coord < 5'd20) begin
          check("cell_occupied", 32'(cell_occupied), 32'(m_occ[y_coord][x_coord]));
          if (m_occ[y_coord][x_coord])
            check("cell_color", 32'(cell_color), 32'(m_col[y_coord][x_coord]));
        end else begin
          check("cell_oob", 32'(cell_occupied), 32'd0);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [19:0] pk(input logic [4:0] a, input logic [4:0] b,
                                     input logic [4:0] c, input logic [4:0] d);
    return {d, c, b, a};
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic start_lock(input logic [19:0] xb, input logic [19:0] yb, input logic [2:0] c);
    x_block = xb; y_block = yb; block = c; get_new_block = 1'b1;
    @(posedge Clk); #1;
    get_new_block = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    bit done;
    done = 1'b0;
    cyc = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge Clk);
      if (!BOARD_BUSY) done = 1'b1;
      else cyc++;
    end
    if (!done) check("idle_timeout", 32'd1, 32'd0);
    @(posedge Clk); #1;
  endtask

  task automatic lock_piece(input logic [19:0] xb, input logic [19:0] yb, input logic [2:0] c,
                            output int cyc);
    start_lock(xb, yb, c);
    wait_idle(cyc);
  endtask

  task automatic expect_cell(input string nm, input logic [4:0] x, input logic [4:0] y,
                             input logic exp);
    x_coord = x; y_coord = y;
    @(negedge Clk);
    check(nm, 32'(cell_occupied), 32'(exp));
    @(posedge Clk); #1;
  endtask

  task automatic expect_empty_board();
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) expect_cell("board_empty", 5'(x), 5'(y), 1'b0);
  endtask

  function automatic logic [4:0] rx();
    if ($urandom % 100 < 85) return 5'($urandom % 10);
    return 5'(10 + $urandom % 22);
  endfunction

  function automatic logic [4:0] ry();
    int p;
    p = int'($urandom % 100);
    if (p < 70) return 5'(16 + $urandom % 4);
    if (p < 90) return 5'($urandom % 22);
    return 5'(28 + $urandom % 4);
  endfunction

  function automatic logic [19:0] rpx();
    return pk(rx(), rx(), rx(), rx());
  endfunction

  function automatic logic [19:0] rpy();
    return pk(ry(), ry(), ry(), ry());
  endfunction

  // ---------------- stimulus ----------------
  int cyc;
  logic [19:0] y19;

  initial begin
    y19 = pk(19, 19, 19, 19);
    @(posedge Clk); #1;
    chk_en = 1'b1;
    do_reset();

    // Reset state and empty-board candidate checks around a T piece.
    @(negedge Clk);
    check("rst_busy", 32'(BOARD_BUSY), 32'd0);
    check("rst_lines", 32'(lines_cleared), 32'd0);
    check("rst_go", 32'(game_over), 32'd0);
    @(posedge Clk); #1;
    x_move_left    = pk(3, 4, 4, 5); y_move_left    = pk(1, 0, 1, 1);
    x_move_right   = pk(5, 6, 6, 7); y_move_right   = pk(1, 0, 1, 1);
    x_rotate_right = pk(5, 5, 5, 6); y_rotate_right = pk(0, 1, 2, 1);
    x_rotate_left  = pk(4, 5, 5, 5); y_rotate_left  = pk(1, 0, 1, 2);
    x_move_down    = pk(4, 5, 5, 6); y_move_down    = pk(2, 1, 2, 2);
    @(negedge Clk);
    check("empty_can_move", 32'(can_move), 32'h1f);
    @(posedge Clk); #1;
    x_move_left = pk(31, 0, 0, 1);
    @(negedge Clk);
    check("left_wall", 32'(can_move), 32'h0f);
    @(posedge Clk); #1;

    // Single clear: row 19 filled by an I piece, marker at (2,18) drops to row 19.
    lock_piece(pk(0, 1, 2, 3), y19, 3'd1, cyc);
    check("busy_no_clear", 32'(cyc), 32'd21);
    lock_piece(pk(4, 5, 2, 5), pk(19, 19, 18, 19), 3'd2, cyc);
    lock_piece(pk(6, 7, 8, 9), y19, 3'd3, cyc);
    check("busy_one_clear", 32'(cyc), 32'd42);
    check("lines_one", 32'(lines_cleared), 32'd1);
    expect_cell("row19_col0", 5'd0, 5'd19, 1'b0);
    expect_cell("row19_col9", 5'd9, 5'd19, 1'b0);
    expect_cell("marker_dropped", 5'd2, 5'd19, 1'b1);
    check("marker_color", 32'(cell_color), 32'd2);
    expect_cell("marker_gone", 5'd2, 5'd18, 1'b0);

    // Tetris: rows 16..19 full except column 9, closed with a vertical I.
    do_reset();
    for (int r = 16; r < 20; r++) begin
      lock_piece(pk(0, 1, 2, 3), pk(5'(r), 5'(r), 5'(r), 5'(r)), 3'd4, cyc);
      lock_piece(pk(4, 5, 6, 7), pk(5'(r), 5'(r), 5'(r), 5'(r)), 3'd5, cyc);
    end
    lock_piece(pk(8, 8, 8, 8), pk(16, 17, 18, 19), 3'd6, cyc);
    lock_piece(pk(9, 9, 9, 9), pk(16, 17, 18, 19), 3'd7, cyc);
    check("busy_tetris", 32'(cyc), 32'd105);
    check("lines_tetris", 32'(lines_cleared), 32'd4);
    expect_empty_board();

    // Two clears with a partial row above them that must land on row 19.
    do_reset();
    for (int r = 18; r < 20; r++) begin
      lock_piece(pk(0, 1, 2, 3), pk(5'(r), 5'(r), 5'(r), 5'(r)), 3'd1, cyc);
      lock_piece(pk(4, 5, 6, 7), pk(5'(r), 5'(r), 5'(r), 5'(r)), 3'd1, cyc);
    end
    lock_piece(pk(8, 8, 3, 3), pk(18, 19, 17, 17), 3'd2, cyc);
    lock_piece(pk(9, 9, 9, 9), pk(18, 19, 19, 18), 3'd3, cyc);
    check("busy_two_clear", 32'(cyc), 32'd63);
    check("lines_two", 32'(lines_cleared), 32'd2);
    expect_cell("gap_row_landed", 5'd3, 5'd19, 1'b1);
    expect_cell("gap_row_left", 5'd3, 5'd17, 1'b0);
    expect_cell("gap_row_neighbour", 5'd0, 5'd19, 1'b0);

    // Down moves blocked by the floor and by a locked cell.
    do_reset();
    lock_piece(pk(0, 0, 0, 0), y19, 3'd1, cyc);
    x_move_left = pk(5, 5, 5, 5); x_move_right = pk(5, 5, 5, 5);
    y_move_left = pk(5, 5, 5, 5); y_move_right = pk(5, 5, 5, 5);
    x_move_down = pk(4, 5, 5, 6); y_move_down = pk(20, 19, 20, 20);
    @(negedge Clk);
    check("down_floor", 32'(can_move), 32'h1e);
    @(posedge Clk); #1;
    x_move_down = pk(0, 1, 1, 2); y_move_down = pk(19, 18, 18, 18);
    @(negedge Clk);
    check("down_occupied", 32'(can_move), 32'h1e);
    @(posedge Clk); #1;
    x_move_down = pk(1, 1, 1, 1); y_move_down = y19;
    @(negedge Clk);
    check("down_free", 32'(can_move), 32'h1f);
    @(posedge Clk); #1;

    // Reset while a row is being shifted down.
    do_reset();
    lock_piece(pk(0, 1, 2, 3), y19, 3'd1, cyc);
    lock_piece(pk(4, 5, 6, 7), y19, 3'd1, cyc);
    lock_piece(pk(8, 8, 8, 1), pk(19, 19, 19, 18), 3'd1, cyc);
    start_lock(pk(9, 9, 9, 9), y19, 3'd2);
    repeat (3) begin @(posedge Clk); #1; end
    @(negedge Clk);
    check("busy_mid_shift", 32'(BOARD_BUSY), 32'd1);
    @(posedge Clk); #1;
    do_reset();
    @(negedge Clk);
    check("rst_shift_busy", 32'(BOARD_BUSY), 32'd0);
    check("rst_shift_lines", 32'(lines_cleared), 32'd0);
    @(posedge Clk); #1;
    expect_empty_board();

    // Top-out is sticky until reset.
    lock_piece(pk(3, 3, 4, 4), pk(0, 1, 0, 1), 3'd5, cyc);
    @(negedge Clk);
    check("topout_set", 32'(game_over), 32'd1);
    @(posedge Clk); #1;
    lock_piece(pk(0, 0, 0, 0), pk(10, 10, 10, 10), 3'd5, cyc);
    @(negedge Clk);
    check("topout_sticky", 32'(game_over), 32'd1);
    @(posedge Clk); #1;
    do_reset();
    @(negedge Clk);
    check("topout_cleared", 32'(game_over), 32'd0);
    @(posedge Clk); #1;

    // Randomized traffic, including requests while busy and occasional resets.
    for (int n = 0; n < 8000; n++) begin
      x_block = rpx(); y_block = rpy(); block = 3'($urandom % 8);
      get_new_block = ($urandom % 4 == 0);
      x_move_left = rpx();    y_move_left = rpy();
      x_move_right = rpx();   y_move_right = rpy();
      x_rotate_right = rpx(); y_rotate_right = rpy();
      x_rotate_left = rpx();  y_rotate_left = rpy();
      x_move_down = rpx();    y_move_down = rpy();
      x_coord = rx(); y_coord = ry();
      Reset = ($urandom % 900 == 0);
      @(posedge Clk); #1;
    end
    Reset = 1'b0;
    get_new_block = 1'b0;
    wait_idle(cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/board_state.md
# board_state

Board-side counterpart of the falling-piece controller. Holds the 10x20 locked-cell playfield and answers the controller's five candidate-move queries with `can_move`. Locks the active tetromino when the controller requests a new block, then scans for and clears full rows while holding `BOARD_BUSY`. Also serves per-cell occupancy and colour to the VGA pixel path.

## Interface
- `COLS`, 10: playfield width in cells.
- `ROWS`, 20: playfield height in cells.
- `Clk`  in  1  system clock, 50 MHz.
- `Reset`  in  1  synchronous, active-high reset.
- `x_block`, `y_block`  in  20 each  active piece, four packed 5-bit cell coordinates; cell i is bits [5i+4:5i].
- `block`  in  block_color  colour of the active piece.
- `get_new_block`  in  1  lock request; the active piece is still valid in this cycle.
- `x_move_left`/`y_move_left`, `x_move_right`/`y_move_right`, `x_rotate_right`/`y_rotate_right`, `x_rotate_left`/`y_rotate_left`, `x_move_down`/`y_move_down`  in  20 each  candidate piece positions.
- `x_coord`, `y_coord`  in  5 each  display read address.
- `can_move`  out  5  validity of each candidate: [4] left, [3] right, [2] rotate right, [1] rotate left, [0] down.
- `BOARD_BUSY`  out  1  high while locking or clearing rows.
- `cell_occupied`  out  1  occupancy at (`x_coord`, `y_coord`).
- `cell_color`  out  block_color  colour at (`x_coord`, `y_coord`).
- `lines_cleared`  out  16  total rows cleared since reset; wraps at 65535.
- `game_over`  out  1  sticky top-out flag.

## Operation
- **Storage:** ROWS x COLS cells, each holding an occupied bit plus a block_color. Row 0 is the top row; x increases to the right.
- **Candidate check (combinational):**
  - A cell is legal iff x <= 9, y <= 19, and the board cell is unoccupied.
  - A 5-bit x of 31 (left-wall underflow) is therefore illegal.
  - Each `can_move` bit is the AND of its candidate's four cell checks.
  - `can_move` is forced to 5'b0 whenever `BOARD_BUSY` is high.
- **Read port (combinational):** `cell_occupied` and `cell_color` come from the addressed cell. Out-of-range addresses return occupied=0.
- **FSM states:** IDLE, LOCK, SCAN, SHIFT.
- **IDLE:**
  - `BOARD_BUSY` is low.
  - On `get_new_block`, capture `x_block`, `y_block` and `block` into holding registers and go to LOCK.
- **LOCK (1 cycle):**
  - Write all four captured cells as occupied with the captured colour. Out-of-range cells are dropped.
  - Set `game_over` if any captured y == 0.
  - Load the row pointer r = 19 and go to SCAN.
- **SCAN (1 cycle per row):**
  - If row r is full, load the shift pointer s = r and go to SHIFT.
  - Otherwise, if r == 0, go to IDLE; else decrement r and stay in SCAN.
- **SHIFT (1 cycle per row moved):**
  - If s > 0, copy row s-1 into row s and decrement s.
  - If s == 0, clear row 0, increment `lines_cleared`, and return to SCAN with r unchanged, so the row that dropped into r is rechecked.
- **Ignored input:** `get_new_block` outside IDLE is ignored. The controller gates its own state on `BOARD_BUSY`, so this does not occur in normal use.

## Timing
- **Reset (next edge):**
  - All cells empty, FSM in IDLE.
  - `BOARD_BUSY`=0, `lines_cleared`=0, `game_over`=0.
  - Reset takes priority mid-LOCK, mid-SCAN or mid-SHIFT; the board is cleared with no partial shift remaining.
- **`BOARD_BUSY` rise:** registered. It is high starting the cycle after the capture edge and stays high through the final SCAN of row 0.
- **Lock latency:** new cells are visible on the read and check ports one cycle after capture (end of LOCK).
- **No clear:** busy for 21 cycles (LOCK + 20 SCAN).
- **Each clear at row r:** adds r+1 SHIFT cycles plus one rescan of row r.
- **Worst case:** four rows cleared at 19..16 gives 21 + 20+1 + 20+1 + 20+1 + 20+1 = 105 cycles. This is well under one frame.
- **`game_over`:** only Reset clears it. The board keeps operating after it is set.

## Test plan
- **Empty board:** Reset, then T piece x={4,5,5,6}, y={1,0,1,1}, candidates shifted one step -> `can_move`=5'b11111. With x_move_left cell x=31 -> bit4=0.
- **Lock:** Set row 19 x=0..5 occupied. Lock I piece x={6,7,8,9}, y=19 -> `BOARD_BUSY` high 21+20+1 cycles. Row 19 then empty, `lines_cleared`=1, rows shifted down by one.
- **Tetris:** Fill rows 16-19 except col 9. Lock vertical I at x=9, y=16..19 -> 105 busy cycles, `lines_cleared`=4, board empty.
- **Gap row preserved:** Rows 18 and 19 full after lock, row 17 partial -> row 17 contents end at row 19, `lines_cleared`=2.
- **Down blocked:** Piece resting on the row-19 floor, y_move_down containing y=20 -> `can_move[0]`=0. Down candidate onto an occupied cell -> 0.
- **Reset mid-SHIFT / top-out:** Assert Reset during SHIFT -> next cycle all cells empty, busy=0, count=0. Lock a piece with a cell at y=0 -> `game_over`=1 until Reset.
